// File: rtl/bitbrick_pkg.sv
// bitbrick_pkg: shared precision encodings, FSM states and slice helpers
package bitbrick_pkg;
  localparam int BRICK_W = 2;
  localparam int PROD_W = 4;
  localparam logic [1:0] PREC_2 = 2'b00;
  localparam logic [1:0] PREC_4 = 2'b01;
  localparam logic [1:0] PREC_8 = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
  function automatic logic [2:0] slice_cnt(input logic [1:0] prec);
    return prec == PREC_2 ? 3'd1 : prec == PREC_4 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/bitbrick.sv
// bitbrick: 2b x 2b multiplier, each operand optionally signed via sel={a_signed,w_signed}
module bitbrick
  import bitbrick_pkg::*;
(
  input  logic [BRICK_W-1:0] a,
  input  logic [BRICK_W-1:0] w,
  input  logic [1:0]         sel,
  output logic [PROD_W-1:0]  p
);
  logic signed [BRICK_W:0]  w_a;
  logic signed [BRICK_W:0]  w_w;
  logic signed [PROD_W-1:0] w_p;
  assign w_a = {sel[1] & a[BRICK_W-1], a};
  assign w_w = {sel[0] & w[BRICK_W-1], w};
  assign w_p = w_a * w_w;
  assign p   = w_p;
endmodule

// File: rtl/bitbrick_seq_mac.sv
// bitbrick_seq_mac: sequential 2/4/8-bit MAC over one bitbrick; BBSEQ_SAT_EN enables saturation and out_sat
module bitbrick_seq_mac
  import bitbrick_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_w,
  input  logic [1:0]       in_prec_a,
  input  logic [1:0]       in_prec_w,
  input  logic             in_sgn_a,
  input  logic             in_sgn_w,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
`ifdef BBSEQ_SAT_EN
  ,
  output logic             out_sat
`endif
);
`ifdef BBSEQ_SAT_EN
  localparam int SW = ACC_W + 2;
`else
  localparam int SW = ACC_W;
`endif
  state_t             r_state, w_state_nxt;
  logic [7:0]         r_a, r_w;
  logic [1:0]         r_amax, r_wmax, r_i, r_j;
  logic               r_sa, r_sw, r_last;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [1:0]         w_sel;
  logic [PROD_W-1:0]  w_p;
  logic [2:0]         w_k;
  logic [SW-1:0]      w_ext, w_term;
  logic               w_done;
  assign w_sel  = {r_sa && r_i == r_amax, r_sw && r_j == r_wmax};
  assign w_done = r_i == r_amax && r_j == r_wmax;
  assign w_k    = {1'b0, r_i} + {1'b0, r_j};
  assign w_ext  = |w_sel ? {{(SW-PROD_W){w_p[PROD_W-1]}}, w_p} : {{(SW-PROD_W){1'b0}}, w_p};
  assign w_term = w_ext << {w_k, 1'b0};
  bitbrick u_brick (
    .a   (r_a[{r_i, 1'b0} +: BRICK_W]),
    .w   (r_w[{r_j, 1'b0} +: BRICK_W]),
    .sel (w_sel),
    .p   (w_p)
  );
`ifdef BBSEQ_SAT_EN
  logic [ACC_W+1:0] w_sum;
  logic             w_ovf;
  logic             r_sat;
  assign w_sum     = {{2{r_acc[ACC_W-1]}}, r_acc} + w_term;
  assign w_ovf     = !(&w_sum[ACC_W+1:ACC_W-1]) && |w_sum[ACC_W+1:ACC_W-1];
  assign w_acc_nxt = w_ovf ? {w_sum[ACC_W+1], {(ACC_W-1){!w_sum[ACC_W+1]}}} : w_sum[ACC_W-1:0];
  assign out_sat   = r_sat;
  // sticky saturation flag, cleared together with the accumulator
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_sat <= 1'b0;
    else if (r_state == RUN) r_sat <= r_sat | w_ovf;
    else if (r_state == OUT && out_ready) r_sat <= 1'b0;
`else
  assign w_acc_nxt = r_acc + w_term;
`endif
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == OUT;
  assign out_data  = r_acc;
  // state register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // next state: accept in IDLE, walk slices in RUN, hold result in OUT until taken
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = in_valid ? RUN : IDLE;
      RUN:     w_state_nxt = w_done ? (r_last ? OUT : IDLE) : RUN;
      OUT:     w_state_nxt = out_ready ? IDLE : OUT;
      default: w_state_nxt = IDLE;
    endcase
  end
  // operand latch, slice counters (a inner, w outer) and accumulator
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      r_a    <= '0;
      r_w    <= '0;
      r_amax <= '0;
      r_wmax <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_sa   <= 1'b0;
      r_sw   <= 1'b0;
      r_last <= 1'b0;
      r_acc  <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a    <= in_a;
          r_w    <= in_w;
          r_amax <= 2'(slice_cnt(in_prec_a) - 3'd1);
          r_wmax <= 2'(slice_cnt(in_prec_w) - 3'd1);
          r_sa   <= in_sgn_a;
          r_sw   <= in_sgn_w;
          r_last <= in_last;
          r_i    <= '0;
          r_j    <= '0;
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_i   <= r_i == r_amax ? 2'd0 : r_i + 2'd1;
          r_j   <= r_i == r_amax ? r_j + 2'd1 : r_j;
        end
        OUT: if (out_ready) r_acc <= '0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_bitbrick_seq_mac.sv
// tb_bitbrick_seq_mac: directed and randomized checks of bitbrick_seq_mac against an integer dot-product model
module tb_bitbrick_seq_mac;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_a = '0, in_w = '0;
  logic [1:0]   in_prec_a = '0, in_prec_w = '0;
  logic         in_sgn_a = 1'b0, in_sgn_w = 1'b0, in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
`ifdef BBSEQ_SAT_EN
  logic         out_sat;
`endif
  int errors = 0;
  int checks = 0;

  bitbrick_seq_mac #(.ACC_W(W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_w      (in_w),
    .in_prec_a (in_prec_a),
    .in_prec_w (in_prec_w),
    .in_sgn_a  (in_sgn_a),
    .in_sgn_w  (in_sgn_w),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BBSEQ_SAT_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  always #5 clk = ~clk;

  function automatic longint opval(input logic [7:0] x, input logic [1:0] prec, input logic sgn);
    int b;
    longint v;
    b = prec == 2'd0 ? 2 : prec == 2'd1 ? 4 : 8;
    v = longint'(x) & ((longint'(1) << b) - 1);
    if (sgn && v >= (longint'(1) << (b - 1))) v = v - (longint'(1) << b);
    return v;
  endfunction

  function automatic int nslice(input logic [1:0] prec);
    return prec == 2'd0 ? 1 : prec == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [W-1:0] fold(input longint s);
    logic [63:0] u;
`ifdef BBSEQ_SAT_EN
    if (s > (longint'(1) << (W - 1)) - 1) s = (longint'(1) << (W - 1)) - 1;
    if (s < -(longint'(1) << (W - 1))) s = -(longint'(1) << (W - 1));
`endif
    u = s;
    return u[W-1:0];
  endfunction

  function automatic bit over(input longint s);
    return s > (longint'(1) << (W - 1)) - 1 || s < -(longint'(1) << (W - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] w, input logic [1:0] pa, input logic [1:0] pw,
                      input logic sa, input logic sw, input logic last);
    int n;
    in_a = a; in_w = w; in_prec_a = pa; in_prec_w = pw;
    in_sgn_a = sa; in_sgn_w = sw; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 200) begin
      tick();
      k++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
  endtask

  task automatic test_single(input string nm, input logic [7:0] a, input logic [7:0] w, input logic [1:0] pa,
                             input logic [1:0] pw, input logic sa, input logic sw);
    int k;
    logic [W-1:0] exp;
    exp = fold(opval(a, pa, sa) * opval(w, pw, sw));
    send(a, w, pa, pw, sa, sw, 1'b1);
    wait_out(k);
    checks++; if (out_valid !== 1'b1 || k != nslice(pa) * nslice(pw)) begin
      errors++; $display("FAIL %s_latency: valid=%0b after %0d cycles, want 1 after %0d", nm, out_valid, k, nslice(pa) * nslice(pw));
    end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL %s_data: got %h want %h", nm, out_data, exp); end
    take();
  endtask

  task automatic test_accumulate();
    int k;
    send(8'h08, 8'h07, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_no_out: out_valid=%0b cycle %0d want 0", out_valid, c); end
      tick();
    end
    send(8'h07, 8'h07, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1);
    wait_out(k);
    checks++; if (out_valid !== 1'b1 || out_data !== fold(-8 * 7 + 7 * 7)) begin
      errors++; $display("FAIL acc_sum: valid=%0b data=%h want 1/%h", out_valid, out_data, fold(-7));
    end
    take();
    send(8'h01, 8'h01, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1);
    wait_out(k);
    checks++; if (out_valid !== 1'b1 || out_data !== fold(1)) begin
      errors++; $display("FAIL acc_cleared: valid=%0b data=%h want 1/%h", out_valid, out_data, fold(1));
    end
    take();
  endtask

  task automatic test_backpressure();
    int k;
    logic [W-1:0] exp;
    exp = fold(opval(8'hB6, 2'd1, 1'b0) * opval(8'h9D, 2'd1, 1'b1));
    send(8'hB6, 8'h9D, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1);
    wait_out(k);
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold: cycle %0d valid=%0b data=%h ready=%0b want 1/%h/0", c, out_valid, out_data, in_ready, exp);
      end
      tick();
    end
    take();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      errors++; $display("FAIL bp_release: valid=%0b ready=%0b data=%h want 0/1/0", out_valid, in_ready, out_data);
    end
  endtask

  task automatic test_reset_mid();
    send(8'hA5, 8'h5A, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1);
    repeat (5) tick();
    nrst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL mid_reset: ready=%0b valid=%0b data=%h want 1/0/0", in_ready, out_valid, out_data);
    end
    tick();
    nrst = 1'b1;
    repeat (20) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_partial: out_valid=%0b want 0", out_valid); end
      tick();
    end
    test_single("mid_next", 8'h02, 8'h03, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    int k;
    longint s;
    s = 3 * 127 * 127;
    for (int p = 0; p < 3; p++) send(8'h7F, 8'h7F, 2'd2, 2'd2, 1'b0, 1'b0, p == 2);
    wait_out(k);
    checks++; if (out_valid !== 1'b1 || out_data !== fold(s)) begin
      errors++; $display("FAIL overflow_data: valid=%0b data=%h want 1/%h", out_valid, out_data, fold(s));
    end
`ifdef BBSEQ_SAT_EN
    checks++; if (out_sat !== over(s)) begin errors++; $display("FAIL overflow_sat: got %0b want %0b", out_sat, over(s)); end
`endif
    take();
  endtask

  task automatic test_random();
    int k, n;
    longint s;
    logic [7:0] a, w;
    logic [1:0] pa, pw;
    logic sa, sw;
    for (int t = 0; t < 25; t++) begin
`ifdef BBSEQ_SAT_EN
      n = 1;
`else
      n = $urandom_range(1, 3);
`endif
      s = 0;
      for (int p = 0; p < n; p++) begin
        a = 8'($urandom); w = 8'($urandom);
        pa = 2'($urandom); pw = 2'($urandom);
        sa = 1'($urandom); sw = 1'($urandom);
`ifdef BBSEQ_SAT_EN
        if (pa[1] && pw[1]) pw = 2'd1;
`endif
        s = s + opval(a, pa, sa) * opval(w, pw, sw);
        send(a, w, pa, pw, sa, sw, p == n - 1);
      end
      wait_out(k);
      checks++; if (out_valid !== 1'b1 || k != nslice(pa) * nslice(pw)) begin
        errors++; $display("FAIL rand_latency %0d: valid=%0b after %0d want 1 after %0d", t, out_valid, k, nslice(pa) * nslice(pw));
      end
      checks++; if (out_data !== fold(s)) begin errors++; $display("FAIL rand_data %0d: got %h want %h", t, out_data, fold(s)); end
`ifdef BBSEQ_SAT_EN
      checks++; if (out_sat !== over(s)) begin errors++; $display("FAIL rand_sat %0d: got %0b want %0b", t, out_sat, over(s)); end
`endif
      take();
    end
  endtask

  initial begin
    test_reset();
    test_single("u2b", 8'hF3, 8'hFE, 2'd0, 2'd0, 1'b0, 1'b0);
    test_single("s8b", 8'hFD, 8'h05, 2'd2, 2'd2, 1'b1, 1'b1);
    test_single("s8b_rsv", 8'h81, 8'h80, 2'd3, 2'd2, 1'b1, 1'b1);
    test_accumulate();
    test_backpressure();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bitbrick_seq_mac.md
Name: bitbrick_seq_mac

Overview:
- Sequential multi-precision multiply-accumulate built around one `bitbrick` (2b x 2b -> 4b product, `sel` = {a_signed, w_signed}).
- Sits on both sides of the brick:
  - upstream, it slices 2/4/8-bit activation and weight operands into 2-bit bricks and drives the brick's `a`, `w` and `sel` inputs;
  - downstream, it shift-adds each 4-bit `p` into a wide accumulator.
- Emits one accumulated dot-product result per `in_last`.

Parameters:
- ACC_W, 24, accumulator and `out_data` width; legal range 16..32.

Ports:
- clk        in   1      clock; all state changes on its rising edge
- nrst       in   1      reset, asynchronous, active-low
- in_valid   in   1      operand pair valid
- in_ready   out  1      block can accept an operand pair
- in_a       in   8      activation; LSB-aligned to in_prec_a
- in_w       in   8      weight; LSB-aligned to in_prec_w
- in_prec_a  in   2      activation width: 00=2b, 01=4b, 10=8b, 11=8b (reserved)
- in_prec_w  in   2      weight width, same encoding
- in_sgn_a   in   1      activation is two's complement
- in_sgn_w   in   1      weight is two's complement
- in_last    in   1      emit result after this pair
- out_valid  out  1      result valid
- out_ready  in   1      consumer accepts result
- out_data   out  ACC_W  accumulated result, two's complement

Behaviour:
- Reset (async assert, synchronous deassert use):
  - state=IDLE, acc=0, out_valid=0, in_ready=1, out_data=0, slice counters=0.
  - Reset asserted mid-RUN or mid-OUT aborts the operation; no partial result is emitted.
- FSM states IDLE, RUN, OUT:
  - IDLE: in_ready=1. When in_valid is high, latch operands, precisions, signs and last, then go to RUN. in_ready=0 in RUN and OUT.
  - RUN: each cycle feeds one slice pair to the brick and adds its product into acc.
    - Slice counts: Na = prec_a/2 ∈ {1,2,4}, Nw = prec_w/2 ∈ {1,2,4}. Total Na*Nw cycles.
    - Order: j (w slice) outer, i (a slice) inner, both from 0 upwards.
  - RUN exit after the last slice pair: if the latched last=1, go to OUT; otherwise go to IDLE with acc retained.
  - OUT: out_valid=1 and out_data=acc, both stable until out_ready. On the handshake: acc<=0, out_valid<=0, go to IDLE.
- Slice sign handling:
  - The brick's a-sign bit is set only for the top a slice (i==Na-1) and only when sgn_a=1. Likewise the w-sign bit uses j==Nw-1 and sgn_w.
  - If either sign bit is set, p is sign-extended from 4 bits; otherwise it is zero-extended.
- Each RUN cycle: acc <= acc + (ext(p) << 2*(i+j)), all in ACC_W two's complement.
  - Wrap-around on overflow, unless BBSEQ_SAT_EN is defined.
- Operand bits above the selected precision are ignored.
- Timing:
  - The brick is combinational inside this block.
  - Latency from accept cycle t to out_valid is t+Na*Nw+1.
  - Minimum interval between accepts is Na*Nw+1 cycles, because of the IDLE bubble.
- in_valid while in_ready=0 is held by the producer; no operand pair is dropped and none is duplicated.

Optional Feature:
- BBSEQ_SAT_EN defined:
  - Each accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A sticky sat flag is cleared with acc.
  - The flag is exposed as output port `out_sat` (1b), valid with out_valid and reset to 0.
- BBSEQ_SAT_EN undefined: modular wrap, and no `out_sat` port.

Decomposition:
- Package `bitbrick_pkg`:
  - precision encodings PREC_2/PREC_4/PREC_8;
  - state enum IDLE/RUN/OUT;
  - slice-count function prec→N;
  - BRICK_W=2 and PROD_W=4.
- One sub-module: the existing `bitbrick`, instantiated once.
- Slicing, shift and accumulate logic stays in `bitbrick_seq_mac`.

Test Plan:
- Reset values: hold nrst low, then release → in_ready=1, out_valid=0, out_data=0.
- 2b unsigned: a=3, w=2, last=1 → single RUN cycle; out_data=6; out_valid at accept+2.
- 8b signed: a=0xFD (-3), w=0x05, both signed, last=1 → 16 RUN cycles; out_data=0xFFFFF1 (-15); out_valid at accept+17.
- Accumulate across pairs, 4b signed throughout:
  - first pair a=-8, w=7, last=0 → no out_valid;
  - second pair a=7, w=7, last=1 → out_data=-7;
  - next single pair a=1, w=1, last=1 → out_data=1, proving acc cleared.
- Backpressure: hold out_ready=0 for 5 cycles in OUT → out_valid, out_data stable and in_ready=0 throughout; then out_ready=1 → handshake, back to IDLE.
- Reset mid-operation and overflow (ACC_W=16):
  - nrst pulsed low during RUN of an 8b×8b op → immediate return to reset values; the next op a=2, w=3 (2b) gives 6.
  - Three pairs of 127×127 (8b unsigned) with last on the third → out_data=-17149 wrap without BBSEQ_SAT_EN; 32767 with out_sat=1 when BBSEQ_SAT_EN is defined.
